// File: rtl/locked_serial_adder_pkg.sv
// Shared definitions for the key-locked multi-lane serial adder:
// state encoding, default unlock key and a width helper.
package locked_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_LOCKOUT = 2'd1,
        ST_IDLE    = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam int          KEY_LEN_DEFAULT = 16;
    localparam logic [15:0] KEY_DEFAULT     = 16'hA5C3;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/serial_add_lane.sv
// One LSB-first serial adder lane: registered sum bit, carry chain and
// overflow flag captured on the last bit of the word.
module serial_add_lane #(
    parameter int SIGNED = 0
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic sample_i,
    input  logic last_i,
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic ovf_o
);

    logic sum_q, sum_d;
    logic carry_q, carry_d;
    logic ovf_q, ovf_d;
    logic carry_in;
    logic carry_out;
    logic sum_bit;

    always_comb begin
        carry_in  = clear_i ? 1'b0 : carry_q;
        sum_bit   = a_i ^ b_i ^ carry_in;
        carry_out = (a_i & b_i) | (a_i & carry_in) | (b_i & carry_in);

        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        if (sample_i) begin
            sum_d   = sum_bit;
            carry_d = carry_out;
            if (clear_i) begin
                ovf_d = 1'b0;
            end
            // At the MSB, carry_in is the carry into the sign bit.
            if (last_i) begin
                ovf_d = (SIGNED != 0) ? (carry_in ^ carry_out) : carry_out;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/locked_serial_adder.sv
// Key-locked multi-lane serial adder: serial key checker with retry limit
// gating a shared word-sequencing FSM that drives LANES adder lanes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_LOCKED  | collecting key bits; start ignored, adder outputs held at 0
// ST_LOCKOUT | retry limit exhausted; only reset leaves this state
// ST_IDLE    | unlocked, waiting for start (bit 0 sampled with start)
// ST_RUN     | sampling bits 1..WORD_LEN-1 of the current word
module locked_serial_adder
    import locked_serial_adder_pkg::*;
#(
    parameter int                 WORD_LEN  = 8,
    parameter int                 LANES     = 2,
    parameter int                 SIGNED    = 0,
    parameter int                 KEY_LEN   = KEY_LEN_DEFAULT,
    parameter logic [KEY_LEN-1:0] KEY       = KEY_DEFAULT,
    parameter int                 MAX_TRIES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_in,
    input  logic             key_valid,
    input  logic             start,
    input  logic [LANES-1:0] line1,
    input  logic [LANES-1:0] line2,
    output logic [LANES-1:0] outp,
    output logic [LANES-1:0] overflw,
    output logic             word_done,
    output logic             unlocked,
    output logic             locked_out
);

    localparam int BCW = clog2(WORD_LEN);
    localparam int KCW = clog2(KEY_LEN + 1);
    localparam int TCW = clog2(MAX_TRIES + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_LEN - 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
    localparam logic [KCW-1:0] KEY_LAST  = KCW'(KEY_LEN - 1);
    localparam logic [TCW-1:0] TRIES_MAX = TCW'(MAX_TRIES);

    state_e             state_q, state_d;
    logic [KEY_LEN-1:0] key_sr_q, key_sr_d;
    logic [KEY_LEN-1:0] key_shift;
    logic [KCW-1:0]     key_cnt_q, key_cnt_d;
    logic [TCW-1:0]     tries_q, tries_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic               word_done_q, word_done_d;
    logic               lane_clear;
    logic               lane_sample;
    logic               lane_last;

    always_comb begin
        state_d     = state_q;
        key_sr_d    = key_sr_q;
        key_cnt_d   = key_cnt_q;
        tries_d     = tries_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = 1'b0;
        lane_clear  = 1'b0;
        lane_sample = 1'b0;
        lane_last   = 1'b0;
        key_shift   = (key_sr_q << 1) | KEY_LEN'(key_in);

        unique case (state_q)
            ST_LOCKED: begin
                // The key has priority; a concurrent start is simply dropped.
                if (key_valid) begin
                    key_sr_d = key_shift;
                    if (key_cnt_q == KEY_LAST) begin
                        key_cnt_d = '0;
                        if (key_shift == KEY) begin
                            state_d = ST_IDLE;
                        end else begin
                            tries_d = tries_q + 1'b1;
                            if (tries_d == TRIES_MAX) begin
                                state_d = ST_LOCKOUT;
                            end
                        end
                    end else begin
                        key_cnt_d = key_cnt_q + 1'b1;
                    end
                end
            end

            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end

            ST_IDLE: begin
                if (start) begin
                    lane_clear  = 1'b1;
                    lane_sample = 1'b1;
                    bit_cnt_d   = BIT_ONE;
                    state_d     = ST_RUN;
                end
            end

            ST_RUN: begin
                lane_sample = 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    lane_last   = 1'b1;
                    word_done_d = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOCKED;
            key_sr_q    <= '0;
            key_cnt_q   <= '0;
            tries_q     <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_sr_q    <= key_sr_d;
            key_cnt_q   <= key_cnt_d;
            tries_q     <= tries_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_add_lane #(
            .SIGNED(SIGNED)
        ) u_lane (
            .clock_i (clock),
            .reset_ni(reset),
            .clear_i (lane_clear),
            .sample_i(lane_sample),
            .last_i  (lane_last),
            .a_i     (line1[i]),
            .b_i     (line2[i]),
            .sum_o   (outp[i]),
            .ovf_o   (overflw[i])
        );
    end

    assign word_done  = word_done_q;
    assign unlocked   = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign locked_out = (state_q == ST_LOCKOUT);

endmodule
